// File: rtl/led_scan_sequencer.sv
// LED scan sequencer for a rotating LED display.
// Each accepted angle tick starts one slot sweep. A sweep walks every row,
// colour and serial slot of the LED driver chain, one serial bit per four
// clocks (PH_A..PH_D). It drives the band-controller read address
// (row/color/bit_sel), the serial clock SCLK and the per-row latch strobe LAT.
//
// Handshake: angle_tick is a request that is accepted only while the
// sequencer is idle (busy=0) and enable=1. A tick presented while busy is
// dropped and recorded in the sticky overrun flag. A tick presented while
// enable=0 is dropped silently. There is no back-pressure beyond busy.
module led_scan_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       angle_tick,
  input  logic       frame_sync,
  output logic       SCLK,
  output logic       LAT,
  output logic [6:0] angle,
  output logic [4:0] row,
  output logic [1:0] color,
  output logic [3:0] bit_sel,
  output logic       new_frame,
  output logic       busy,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH_A = 3'd1,
    PH_B = 3'd2,
    PH_C = 3'd3,
    PH_D = 3'd4
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] slot_q;
  logic       pending_q;
  logic       accept;
  logic       last_bit;
  logic [6:0] next_angle;

  // A tick starts a sweep only from IDLE with scanning enabled.
  assign accept = (state_q == IDLE) && enable && angle_tick;

  // The final bit of a row is colour 0, slot 0; row 31 ends the sweep.
  assign last_bit = (color == 2'd0) && (slot_q == 4'd0) && (row == 5'd31);

  // A pending or concurrent index mark forces the new angle to zero.
  assign next_angle = (pending_q || frame_sync) ? 7'd0 : angle + 7'd1;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: four phases per bit, back to IDLE after the last bit or on disable.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (angle_tick) state_d = PH_A;
        PH_A:    state_d = PH_B;
        PH_B:    state_d = PH_C;
        PH_C:    state_d = PH_D;
        PH_D:    state_d = last_bit ? IDLE : PH_A;
        default: state_d = IDLE;
      endcase
    end
  end

  // Address counters: load the first bit on accept, step at the end of each bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row    <= 5'd0;
      color  <= 2'd0;
      slot_q <= 4'd0;
    end else if (accept) begin
      row    <= 5'd0;
      color  <= 2'd2;
      slot_q <= 4'd15;
    end else if (enable && (state_q == PH_D) && !last_bit) begin
      if (slot_q != 4'd0) begin
        slot_q <= slot_q - 4'd1;
      end else begin
        slot_q <= 4'd15;
        if (color != 2'd0) begin
          color <= color - 2'd1;
        end else begin
          color <= 2'd2;
          row   <= row + 5'd1;
        end
      end
    end
  end

  // Angle tracking, index-mark pending flag and the buffer-swap pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      angle     <= 7'd127;
      pending_q <= 1'b0;
      new_frame <= 1'b0;
    end else begin
      new_frame <= 1'b0;
      if (accept) begin
        angle     <= next_angle;
        pending_q <= 1'b0;
        new_frame <= (next_angle == 7'd0);
      end else if (frame_sync) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Sticky overrun: an enabled tick arrived while a sweep was running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (angle_tick && enable && (state_q != IDLE)) begin
      overrun <= 1'b1;
    end
  end

  // Outputs decoded from the registered state; SCLK is high in the second half of each bit.
  always_comb begin
    SCLK      = (state_q == PH_C) || (state_q == PH_D);
    LAT       = SCLK && (color == 2'd0) && (slot_q == 4'd0);
    busy      = (state_q != IDLE);
    bit_sel   = (slot_q >= 4'd8) ? (slot_q - 4'd7) : 4'd0;
    state_dbg = state_q;
  end

endmodule

// File: doc/led_scan_sequencer.md
LED_SCAN_SEQUENCER -- requirements
Module: led_scan_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces reset state immediately.
REQ-003 enable  input  1  1 = scanning permitted; 0 = abort to IDLE.
REQ-004 angle_tick  input  1  one-clk pulse, start of next angle slot (position sensor derived).
REQ-005 frame_sync  input  1  one-clk pulse, revolution index mark.
REQ-006 SCLK  output  1  serial clock to LED drivers and band controller.
REQ-007 LAT  output  1  driver data latch strobe.
REQ-008 angle  output  7  current angle slot, to band controller read address.
REQ-009 row  output  5  current row, to band controller read address.
REQ-010 color  output  2  current colour channel (0..2), to band controller.
REQ-011 bit_sel  output  4  bit selector to band controller (0 = pad zero, 1..8 = data bit bit_sel-1).
REQ-012 new_frame  output  1  one-clk buffer-swap pulse to band controller.
REQ-013 busy  output  1  1 while a slot sweep is in progress.
REQ-014 overrun  output  1  sticky: angle_tick arrived during a sweep.

Function
REQ-015 States: IDLE, PH_A, PH_B, PH_C, PH_D; each serial bit occupies PH_A..PH_D (4 clk).
REQ-016 PH_A: address outputs (row, color, bit_sel) take the new bit's values, SCLK=0; PH_B: SCLK=0 (band controller SOUT valid after its 1-clk read latency); PH_C, PH_D: SCLK=1.
REQ-017 Sweep order per slot: row 0..31 outer; color 2,1,0 middle; slot index 15..0 inner; bit_sel = slot-7 for slot 15..8, bit_sel = 0 for slot 7..0.
REQ-018 Sweep length = 32*3*16 = 1536 bits = 6144 clk from first PH_A to final PH_D inclusive.
REQ-019 LAT = 1 during PH_C and PH_D of the final bit (color 0, slot 0) of every row; 0 otherwise.
REQ-020 IDLE + angle_tick=1 + enable=1 -> PH_A next cycle; busy=1 from that PH_A until the final PH_D.
REQ-021 After final PH_D -> IDLE; SCLK=0, LAT=0, row/color/bit_sel hold last values.
REQ-022 angle increments by 1 on each accepted tick before the sweep; wraps 127 -> 0.
REQ-023 frame_sync sets a pending flag; next accepted tick loads angle=0 instead of incrementing, clears flag.
REQ-024 Whenever an accepted tick produces angle=0 (wrap or sync), new_frame=1 for exactly the IDLE->PH_A transition cycle (concurrent with first PH_A).
REQ-025 angle_tick while busy=1: tick ignored (angle unchanged, no sweep), overrun set to 1; cleared only by reset.
REQ-026 frame_sync and angle_tick in the same cycle while IDLE: accepted tick loads angle=0.
REQ-027 enable=0 in any state: IDLE next cycle, SCLK=0, LAT=0, busy=0; angle and pending flag retained.
REQ-028 angle_tick with enable=0: ignored, no overrun.

Reset
REQ-029 rst=0: state IDLE, SCLK=0, LAT=0, new_frame=0, busy=0, overrun=0, angle=127, row=0, color=0, bit_sel=0, pending flag cleared; first tick after reset yields angle=0 with new_frame.
REQ-030 Reset mid-sweep aborts immediately; no further SCLK edge until a new accepted tick.

Verification
REQ-031 Reset, enable=1, one angle_tick -> new_frame pulse, angle=0, exactly 1536 SCLK rising edges, 32 LAT pulses each 2 clk, busy=1 for 6144 clk.
REQ-032 Per-bit check: at each PH_B, (row,color,bit_sel) equals sequence of REQ-017; first bit (0,2,8), bit 9 (0,2,0), last bit (31,0,0).
REQ-033 128 ticks spaced 6200 clk -> angle 0..127 then tick 129 gives angle=0 with new_frame; overrun=0.
REQ-034 Second tick 100 clk after first -> overrun=1, angle unchanged, sweep still 1536 bits.
REQ-035 frame_sync at angle 40 then tick -> angle=0, new_frame=1; enable=0 at bit 500 -> IDLE next clk, SCLK=0, busy=0.
REQ-036 rst=0 asserted mid-sweep between edges -> outputs at reset values without waiting for clk.
